// File: rtl/mmc3_irq_pkg.sv
// mmc3_irq_pkg: shared constants, write-decode enum and decode helper for the MMC3 scanline IRQ block
// Contents: CNT_W_DEFAULT, REG_* {A14,A13,A0} register codes, wr_e write type, decode_wr().
package mmc3_irq_pkg;
    localparam int CNT_W_DEFAULT = 8;
    localparam logic [2:0] REG_LATCH   = 3'b100;
    localparam logic [2:0] REG_RELOAD  = 3'b101;
    localparam logic [2:0] REG_DISABLE = 3'b110;
    localparam logic [2:0] REG_ENABLE  = 3'b111;
    typedef enum logic [2:0] {WR_NONE, WR_LATCH, WR_RELOAD, WR_DISABLE, WR_ENABLE} wr_e;
    function automatic wr_e decode_wr(input logic wr, input logic [2:0] code);
        return !wr                  ? WR_NONE    :
               code == REG_LATCH   ? WR_LATCH   :
               code == REG_RELOAD  ? WR_RELOAD  :
               code == REG_DISABLE ? WR_DISABLE :
               code == REG_ENABLE  ? WR_ENABLE  : WR_NONE;
    endfunction
endpackage

// File: rtl/mmc3_a12_filter.sv
// mmc3_a12_filter: synchronises PPU A12 to M2 and emits a one-cycle event on a qualified rising edge
// Ports: i_m2 (clock, falling edge), i_reset_n (async active-low), i_a12 (raw PPU A12),
//        o_event (registered one-cycle scanline event).
module mmc3_a12_filter #(
    parameter int LOW_CYCLES = 3
) (
    input  logic i_m2,
    input  logic i_reset_n,
    input  logic i_a12,
    output logic o_event
);
    localparam int LW = $clog2(LOW_CYCLES + 2);
    localparam logic [LW-1:0] LOW_MAX = LW'(LOW_CYCLES);
    logic r_sync0, r_sync1, r_prev, r_event;
    logic [LW-1:0] r_low_cnt;
    always_ff @(negedge i_m2 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync0   <= 1'b0;
            r_sync1   <= 1'b0;
            r_prev    <= 1'b0;
            r_event   <= 1'b0;
            r_low_cnt <= '0;
        end else begin
            r_sync0   <= i_a12;
            r_sync1   <= r_sync0;
            r_prev    <= r_sync1;
            // low_cnt still holds the pre-rise low time on the edge where the rise is seen
            r_low_cnt <= r_sync1 ? '0 : (r_low_cnt == LOW_MAX ? r_low_cnt : r_low_cnt + 1'b1);
            r_event   <= r_sync1 & ~r_prev & (r_low_cnt == LOW_MAX);
        end
    end
    assign o_event = r_event;
endmodule

// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq: MMC3 scanline counter with $C000-$FFFF register window driving the cartridge IRQ
// Ports: m2 (clock, falling edge), reset_n (async active-low), romsel/cpu_rw_in/cpu_addr_in/cpu_data_in
//        (CPU write port), ppu_a12 (raw PPU A12), irq (active-low), irq_counter (counter readback).
// Config: MMC3_ALT_IRQ_EN selects Rev A firing (no IRQ on a reload from 0 unless requested by $C001).
module mmc3_scanline_irq
    import mmc3_irq_pkg::*;
#(
    parameter int A12_LOW_CYCLES = 3,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic             m2,
    input  logic             reset_n,
    input  logic             romsel,
    input  logic             cpu_rw_in,
    input  logic [14:0]      cpu_addr_in,
    input  logic [7:0]       cpu_data_in,
    input  logic             ppu_a12,
    output logic             irq,
    output logic [CNT_W-1:0] irq_counter
);
    logic             w_event, w_reload, w_fire, w_unused;
    logic [CNT_W-1:0] w_next_cnt, r_latch, r_counter;
    logic             r_reload_flag, r_enabled, r_pending;
    wr_e              w_wr;
    mmc3_a12_filter #(.LOW_CYCLES(A12_LOW_CYCLES)) u_filter (
        .i_m2      (m2),
        .i_reset_n (reset_n),
        .i_a12     (ppu_a12),
        .o_event   (w_event)
    );
    assign w_unused   = ^cpu_addr_in[12:1];
    assign w_wr       = decode_wr(~romsel & ~cpu_rw_in, {cpu_addr_in[14], cpu_addr_in[13], cpu_addr_in[0]});
    assign w_reload   = (r_counter == '0) | r_reload_flag;
    assign w_next_cnt = w_reload ? r_latch : r_counter - 1'b1;
`ifdef MMC3_ALT_IRQ_EN
    // a plain reload (counter was 0) never fires; only a decrement to 0 or a $C001-requested reload
    assign w_fire     = r_enabled & (w_next_cnt == '0) & (~w_reload | r_reload_flag);
`else
    assign w_fire     = r_enabled & (w_next_cnt == '0);
`endif
    // writes are applied after the event update so they win on the same edge
    always_ff @(negedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            r_latch       <= '0;
            r_counter     <= '0;
            r_reload_flag <= 1'b0;
            r_enabled     <= 1'b0;
            r_pending     <= 1'b0;
        end else begin
            if (w_event) begin
                r_counter     <= w_next_cnt;
                r_reload_flag <= 1'b0;
                if (w_fire) r_pending <= 1'b1;
            end
            if (w_wr == WR_LATCH) r_latch <= CNT_W'(cpu_data_in);
            if (w_wr == WR_RELOAD) begin
                r_counter     <= '0;
                r_reload_flag <= 1'b1;
            end
            if (w_wr == WR_DISABLE) begin
                r_enabled <= 1'b0;
                r_pending <= 1'b0;
            end
            if (w_wr == WR_ENABLE) r_enabled <= 1'b1;
        end
    end
    assign irq         = ~(r_pending & r_enabled);
    assign irq_counter = r_counter;
endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb_mmc3_scanline_irq: scoreboard bench for mmc3_scanline_irq (expected {irq,counter} queued, popped after stimulus)
module tb_mmc3_scanline_irq;
    logic        m2, reset_n, romsel, cpu_rw_in, ppu_a12, irq;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in, irq_counter;
    int          checks = 0;
    int          errors = 0;
    typedef struct {
        string      name;
        logic [8:0] v;
    } exp_t;
    exp_t q[$];

    mmc3_scanline_irq dut (
        .m2          (m2),
        .reset_n     (reset_n),
        .romsel      (romsel),
        .cpu_rw_in   (cpu_rw_in),
        .cpu_addr_in (cpu_addr_in),
        .cpu_data_in (cpu_data_in),
        .ppu_a12     (ppu_a12),
        .irq         (irq),
        .irq_counter (irq_counter)
    );

    initial begin
        m2 = 1'b1;
        forever #5 m2 = ~m2;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    // called at a posedge; the write is sampled on the following falling edge
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr_in = a[14:0];
        cpu_data_in = d;
        romsel      = 1'b0;
        cpu_rw_in   = 1'b0;
        @(posedge m2);
        romsel      = 1'b1;
        cpu_rw_in   = 1'b1;
    endtask

    // low for 'low' sampled cycles, then high; high>=4 lets a qualified event reach the counter
    task automatic pulse(input int low, input int high);
        ppu_a12 = 1'b0;
        repeat (low) @(posedge m2);
        ppu_a12 = 1'b1;
        repeat (high) @(posedge m2);
    endtask

    task automatic test_reset();
        exp_t e;
        q.push_back('{"reset_state", {1'b1, 8'd0}});
        #1;
        e = q.pop_front();
        checks++;
        if ({irq, irq_counter} !== e.v) begin
            errors++;
            $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
        end
        @(posedge m2);
        reset_n = 1'b1;
    endtask

    task automatic test_no_writes();
        exp_t e;
        q.push_back('{"idle_toggle", {1'b1, 8'd0}});
        for (int i = 0; i < 100; i++) begin
            ppu_a12 = ~ppu_a12;
            repeat ($urandom_range(1, 4)) @(posedge m2);
        end
        ppu_a12 = 1'b0;
        repeat (8) @(posedge m2);
        e = q.pop_front();
        checks++;
        if ({irq, irq_counter} !== e.v) begin
            errors++;
            $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
        end
    endtask

    task automatic test_count_down();
        exp_t e;
        wr(16'hC000, 8'd3);
        wr(16'hC001, 8'd0);
        wr(16'hE001, 8'd0);
        for (int i = 0; i < 4; i++) begin
            q.push_back('{$sformatf("countdown_%0d", i), {(i == 3) ? 1'b0 : 1'b1, 8'(3 - i)}});
            pulse(3, 4);
            e = q.pop_front();
            checks++;
            if ({irq, irq_counter} !== e.v) begin
                errors++;
                $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
            end
        end
    endtask

    task automatic test_ack();
        exp_t e;
        q.push_back('{"ack_e000", {1'b1, 8'd0}});
        wr(16'hE000, 8'd0);
        e = q.pop_front();
        checks++;
        if ({irq, irq_counter} !== e.v) begin
            errors++;
            $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
        end
        q.push_back('{"e001_no_reassert", {1'b1, 8'd0}});
        wr(16'hE001, 8'd0);
        e = q.pop_front();
        checks++;
        if ({irq, irq_counter} !== e.v) begin
            errors++;
            $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        int   lows[3]  = '{3, 1, 3};
        int   highs[3] = '{4, 6, 4};
        wr(16'hC000, 8'd5);
        wr(16'hC001, 8'd0);
        q.push_back('{"glitch_reload", {1'b1, 8'd5}});
        q.push_back('{"glitch_short_low", {1'b1, 8'd5}});
        q.push_back('{"glitch_long_low", {1'b1, 8'd4}});
        for (int i = 0; i < 3; i++) begin
            pulse(lows[i], highs[i]);
            e = q.pop_front();
            checks++;
            if ({irq, irq_counter} !== e.v) begin
                errors++;
                $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
            end
        end
    endtask

    task automatic test_latch_zero();
        exp_t e;
        logic rev_irq;
`ifdef MMC3_ALT_IRQ_EN
        rev_irq = 1'b1;
`else
        rev_irq = 1'b0;
`endif
        wr(16'hC000, 8'd0);
        wr(16'hC001, 8'd0);
        q.push_back('{"zero_after_c001", {1'b0, 8'd0}});
        pulse(3, 4);
        e = q.pop_front();
        checks++;
        if ({irq, irq_counter} !== e.v) begin
            errors++;
            $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
        end
        q.push_back('{"zero_ack", {1'b1, 8'd0}});
        wr(16'hE000, 8'd0);
        e = q.pop_front();
        checks++;
        if ({irq, irq_counter} !== e.v) begin
            errors++;
            $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
        end
        q.push_back('{"zero_reenable", {1'b1, 8'd0}});
        wr(16'hE001, 8'd0);
        e = q.pop_front();
        checks++;
        if ({irq, irq_counter} !== e.v) begin
            errors++;
            $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
        end
        for (int i = 0; i < 2; i++) begin
            q.push_back('{$sformatf("zero_reload_%0d", i), {rev_irq, 8'd0}});
            pulse(3, 4);
            e = q.pop_front();
            checks++;
            if ({irq, irq_counter} !== e.v) begin
                errors++;
                $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
            end
        end
    endtask

    task automatic test_same_cycle_ack();
        exp_t e;
        wr(16'hE000, 8'd0);
        wr(16'hC000, 8'd2);
        wr(16'hC001, 8'd0);
        wr(16'hE001, 8'd0);
        pulse(3, 4);
        pulse(3, 4);
        // counter reaches 0 on the 4th falling edge after the rise; the $E000 strobe lands on that edge
        q.push_back('{"same_cycle_ack", {1'b1, 8'd0}});
        ppu_a12 = 1'b0;
        repeat (3) @(posedge m2);
        ppu_a12 = 1'b1;
        repeat (3) @(posedge m2);
        wr(16'hE000, 8'd0);
        e = q.pop_front();
        checks++;
        if ({irq, irq_counter} !== e.v) begin
            errors++;
            $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
        end
        q.push_back('{"same_cycle_no_pending", {1'b1, 8'd0}});
        wr(16'hE001, 8'd0);
        e = q.pop_front();
        checks++;
        if ({irq, irq_counter} !== e.v) begin
            errors++;
            $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        wr(16'hC000, 8'd5);
        wr(16'hC001, 8'd0);
        pulse(3, 4);
        pulse(3, 4);
        q.push_back('{"mid_reset", {1'b1, 8'd0}});
        #2 reset_n = 1'b0;
        #1;
        e = q.pop_front();
        checks++;
        if ({irq, irq_counter} !== e.v) begin
            errors++;
            $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
        end
        @(posedge m2);
        reset_n = 1'b1;
        q.push_back('{"post_reset_event", {1'b1, 8'd0}});
        pulse(3, 4);
        e = q.pop_front();
        checks++;
        if ({irq, irq_counter} !== e.v) begin
            errors++;
            $display("FAIL %s: got irq=%b cnt=%0d, expected irq=%b cnt=%0d", e.name, irq, irq_counter, e.v[8], e.v[7:0]);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        romsel      = 1'b1;
        cpu_rw_in   = 1'b1;
        cpu_addr_in = '0;
        cpu_data_in = '0;
        ppu_a12     = 1'b0;
        test_reset();
        test_no_writes();
        test_count_down();
        test_ack();
        test_glitch();
        test_latch_zero();
        test_same_cycle_ack();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
